// File: rtl/clk_burst_sched_if.sv
// Bundle between the shift engines and the shared serial-clock scheduler.
// Requesters drive req/div/len. The scheduler returns grant, sclk, the strobes and done.
interface clk_burst_sched_if #(
    parameter int NREQ = 2,
    parameter int DIVW = 8,
    parameter int LENW = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DIVW-1:0] div;
    logic [NREQ*LENW-1:0] len;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 sclk;
    logic                 pos_trig;
    logic                 neg_trig;
    logic [NREQ-1:0]      done;

    modport master (
        output req, div, len,
        input  grant, busy, sclk, pos_trig, neg_trig, done
    );

    modport slave (
        input  req, div, len,
        output grant, busy, sclk, pos_trig, neg_trig, done
    );
endinterface

// File: rtl/clk_burst_sched.sv
// Round-robin sharing of one divided sclk generator. Grant follows req by 1 cycle; a burst is D*L RUN cycles plus 1 FIN cycle.
// A requester holds req until done. Dropping req aborts the burst, and losers wait without losing their request.
module clk_burst_sched #(
    parameter int NREQ = 2,
    parameter int DIVW = 8,
    parameter int LENW = 8
) (
    input  logic               CLK50MHZ,
    input  logic               rst,
    clk_burst_sched_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] grant_q;
    logic [PW-1:0]   ptr;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] d_last;
    logic [DIVW-1:0] d_half;
    logic [LENW-1:0] pcnt;
    logic [LENW-1:0] lat_len;

    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic [DIVW-1:0] sel_div;
    logic [DIVW-1:0] sel_dlast;
    logic [LENW-1:0] sel_len;
    logic            run;
    logic            tc;
    logic            owner_req;

    assign run       = (state == ST_RUN);
    assign tc        = (cnt == d_last);
    assign owner_req = |(bus.req & grant_q);

    // Scan downwards so the requester closest to the pointer is the last, winning, assignment.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (bus.req[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        sel_div   = bus.div[int'(win_idx)*DIVW +: DIVW];
        sel_len   = bus.len[int'(win_idx)*LENW +: LENW];
        // Divisors of 0 and 1 cannot form a high and a low phase, so they run as 2.
        sel_dlast = (sel_div < DIVW'(2)) ? DIVW'(1) : sel_div - DIVW'(1);
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    state_n = (sel_len != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (!owner_req) begin
                    state_n = ST_IDLE;
                end else if (tc && (pcnt == lat_len - LENW'(1))) begin
                    state_n = ST_FIN;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK50MHZ or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            ptr     <= '0;
            cnt     <= '0;
            pcnt    <= '0;
            d_last  <= '0;
            d_half  <= '0;
            lat_len <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt  <= '0;
                    pcnt <= '0;
                    if (win_vld) begin
                        grant_q <= NREQ'(1) << win_idx;
                        ptr     <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
                        d_last  <= sel_dlast;
                        d_half  <= sel_dlast >> 1;
                        lat_len <= sel_len;
                    end
                end
                ST_RUN: begin
                    if (state_n != ST_RUN) begin
                        // Grant is kept into FIN so done can be steered to the owner.
                        grant_q <= (state_n == ST_FIN) ? grant_q : '0;
                        cnt     <= '0;
                        pcnt    <= '0;
                    end else begin
                        cnt <= tc ? '0 : cnt + DIVW'(1);
                        if (tc) begin
                            pcnt <= pcnt + LENW'(1);
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    cnt     <= '0;
                    pcnt    <= '0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = |grant_q;
    assign bus.sclk     = run && (cnt > d_half);
    assign bus.pos_trig = run && (cnt == d_half);
    assign bus.neg_trig = run && tc;
    assign bus.done     = (state == ST_FIN) ? grant_q : '0;
endmodule

// File: doc/clk_burst_sched.md
Name: clk_burst_sched

Overview:
- Shares one divided serial-clock generator between NREQ requesters (SPI/DAC/ADC-style shifters).
- Each requester asks for a burst of LEN clock periods at its own divisor.
- The block arbitrates round-robin, runs the divider for the granted requester only, and emits sclk, pos_trig and neg_trig strobes plus a per-requester done pulse.
- It sits between the peripheral shift engines and their shared clock line, all in the CLK50MHZ domain.

Parameters:
- NREQ, 2, number of requesters (1..8).
- DIVW, 8, width of each divisor field.
- LENW, 8, width of each burst-length field.

Ports:
- CLK50MHZ  input  1  system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until done or dropped to abort.
- div  input  NREQ*DIVW  packed divisors; field i = div[i*DIVW +: DIVW].
- len  input  NREQ*LENW  packed burst lengths in sclk periods; field i likewise.
- grant  output  NREQ  one-hot owner of the clock; all-zero when idle.
- busy  output  1  OR of grant.
- sclk  output  1  divided clock, low when not RUN.
- pos_trig  output  1  one-cycle strobe, cycle before sclk rises.
- neg_trig  output  1  one-cycle strobe, last cycle of each period (sclk falls after it).
- done  output  NREQ  one-cycle pulse to the owner at end of burst.

Behaviour:
- Reset: state IDLE, grant=0, busy=0, sclk=0, pos_trig=0, neg_trig=0, done=0, divider count=0, period count=0, round-robin pointer = requester 0 has highest priority.
- States: IDLE, RUN, FIN.
- IDLE:
  - On an edge with any req high, pick the first requester at or after the pointer, wrapping.
  - Latch D = max(div_i, 2) and L = len_i. Set grant one-hot and the pointer to winner+1 mod NREQ.
  - Go to RUN if L != 0, else FIN.
  - Grant appears one cycle after req is sampled.
- RUN:
  - Divider count c runs 0..D-1 and wraps to 0.
  - sclk = (c > (D-1)/2), registered or combinational from c, matching the CLK50MHZ-domain convention. Odd D gives low phase one cycle longer.
  - pos_trig = (c == (D-1)/2). neg_trig = (c == D-1).
  - The period counter increments on each neg_trig.
  - On the neg_trig of period L, go to FIN.
  - Example: D=4, L=2 gives exactly 8 RUN cycles.
- FIN:
  - One cycle. done[owner]=1, grant still held, sclk=0, no strobes.
  - Next cycle is IDLE with grant=0.
  - Minimum gap between bursts is one IDLE cycle, so a continuously requesting single requester gets one burst every 8+1+1 cycles at D=4, L=2.
- Abort: if req[owner] is low in any RUN cycle, go to IDLE on the next edge with grant=0, sclk=0, no done, and the period count cleared. Strobes in that cycle may still fire.
- div and len are sampled only in IDLE. Changes mid-burst are ignored.
- Several req rising together: round-robin winner only. Others wait, with no loss of their request.
- req[owner] dropping in FIN: done is still issued.
- Widths:
  - Divider count is DIVW bits. With D=2^DIVW-1 the max count is D-1, so no overflow.
  - Period counter is LENW bits. L=2^LENW-1 is legal.
- Async rst mid-burst: all outputs go to reset values immediately. No done is issued.

Test Plan:
- Single request, div0=4, len0=2:
  - grant=01 one cycle after req.
  - 8 RUN cycles with sclk pattern 0,0,1,1,0,0,1,1.
  - pos_trig at RUN cycles 2,6 and neg_trig at 4,8.
  - done[0] in cycle 9, grant=00 in cycle 10.
- div0=5, len0=1: sclk 0,0,0,1,1; pos_trig at c=2; neg_trig at c=4. Then div0=0 or 1: behaves as D=2, sclk 0,1 per period.
- Both req high together from reset:
  - Requester 0 served first, then requester 1, then 0 again if still requesting.
  - grant never has two bits set.
  - Exactly one done per burst to the right owner.
- len1=0: grant=10 one cycle, then a FIN cycle with done[1]=1, no sclk or strobes, then IDLE.
- Abort: drop req0 at the 3rd RUN cycle of a div=4, len=3 burst. Next cycle grant=00, sclk=0, no done[0]. A pending req1 is granted after the following IDLE cycle.
- Assert rst for one cycle mid-RUN with sclk high: sclk, grant, busy and strobes are 0 immediately. A fresh burst after rst restarts from c=0 with round-robin priority at requester 0.
